// File: rtl/rgb_pixel_packer.sv
// rgb_pixel_packer: packs 24-bit RGB pixels into 8-lane groups.
// Optional line-end padding enabled by RGB_PACKER_LAST_PAD_EN.
module rgb_pixel_packer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [23:0] i_pixel,
  input  logic        i_valid,
  input  logic        i_last,
  output logic        o_ready,
  output logic [23:0] o_data1,
  output logic [23:0] o_data2,
  output logic [23:0] o_data3,
  output logic [23:0] o_data4,
  output logic [23:0] o_data5,
  output logic [23:0] o_data6,
  output logic [23:0] o_data7,
  output logic [23:0] o_data8,
  output logic        o_valid,
  output logic        o_last,
  input  logic        i_ready
);

  logic [23:0] fill [8];
  logic [23:0] lane [8];
  logic [23:0] grp  [8];
  logic [3:0]  cnt;
  logic        fill_last;
  logic        pix_last;
  logic        in_xfer;
  logic        out_free;
  logic        complete;
  logic        release_grp;

`ifdef RGB_PACKER_LAST_PAD_EN
  assign pix_last = i_last;
`else
  assign pix_last = i_last & 1'b0;
`endif

  assign o_ready     = (cnt != 4'd8);
  assign in_xfer     = i_valid & o_ready;
  assign out_free    = ~o_valid | i_ready;
  assign complete    = in_xfer & ((cnt == 4'd7) | pix_last);
  assign release_grp = (cnt == 4'd8) & out_free;

  // Completed group: buffered slots below cnt, incoming pixel at and above it
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      grp[j] = (4'(j) < cnt) ? fill[j] : i_pixel;
    end
  end

  // Fill buffer and fill count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt       <= 4'd0;
      fill_last <= 1'b0;
      for (int j = 0; j < 8; j++) fill[j] <= 24'h0;
    end else if (complete && !out_free) begin
      for (int j = 0; j < 8; j++) fill[j] <= grp[j];
      fill_last <= pix_last;
      cnt       <= 4'd8;
    end else if (complete) begin
      cnt <= 4'd0;
    end else if (in_xfer) begin
      fill[cnt[2:0]] <= i_pixel;
      cnt            <= cnt + 4'd1;
    end else if (release_grp) begin
      cnt <= 4'd0;
    end
  end

  // Output holding register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      for (int j = 0; j < 8; j++) lane[j] <= 24'h0;
    end else if (complete && out_free) begin
      for (int j = 0; j < 8; j++) lane[j] <= grp[j];
      o_valid <= 1'b1;
      o_last  <= pix_last;
    end else if (release_grp) begin
      for (int j = 0; j < 8; j++) lane[j] <= fill[j];
      o_valid <= 1'b1;
      o_last  <= fill_last;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

  assign o_data1 = lane[0];
  assign o_data2 = lane[1];
  assign o_data3 = lane[2];
  assign o_data4 = lane[3];
  assign o_data5 = lane[4];
  assign o_data6 = lane[5];
  assign o_data7 = lane[6];
  assign o_data8 = lane[7];

endmodule

// File: tb/tb_rgb_pixel_packer.sv
// tb_rgb_pixel_packer: directed and random checks against a queue model.
// Build with RGB_PACKER_LAST_PAD_EN to exercise line-end padding.
module tb_rgb_pixel_packer;

`ifdef RGB_PACKER_LAST_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [23:0] i_pixel = 24'h0;
  logic        i_valid = 1'b0;
  logic        i_last = 1'b0;
  logic        i_ready = 1'b0;
  logic        o_ready;
  logic        o_valid;
  logic        o_last;
  logic [23:0] o_data1, o_data2, o_data3, o_data4;
  logic [23:0] o_data5, o_data6, o_data7, o_data8;
  logic [191:0] dut_data;

  int vecs = 0;
  int errs = 0;

  logic [191:0] grp_q [$];
  bit           lst_q [$];
  logic [23:0]  part  [$];

  rgb_pixel_packer dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_pixel(i_pixel),
    .i_valid(i_valid),
    .i_last (i_last),
    .o_ready(o_ready),
    .o_data1(o_data1),
    .o_data2(o_data2),
    .o_data3(o_data3),
    .o_data4(o_data4),
    .o_data5(o_data5),
    .o_data6(o_data6),
    .o_data7(o_data7),
    .o_data8(o_data8),
    .o_valid(o_valid),
    .o_last (o_last),
    .i_ready(i_ready)
  );

  assign dut_data = {o_data8, o_data7, o_data6, o_data5,
                     o_data4, o_data3, o_data2, o_data1};

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [191:0] obs,
                     input logic [191:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    grp_q.delete();
    lst_q.delete();
    part.delete();
  endtask

  // Reference: at most two whole groups in flight (output + stalled)
  task automatic step(input logic v, input logic [23:0] p,
                      input logic l, input logic r, output bit acc);
    logic [191:0] g;
    i_valid = v;
    i_pixel = p;
    i_last  = l;
    i_ready = r;
    #1;
    chk("o_ready", 192'(o_ready), 192'(grp_q.size() < 2));
    chk("o_valid", 192'(o_valid), 192'(grp_q.size() > 0));
    if (grp_q.size() > 0) begin
      chk("o_data", dut_data, grp_q[0]);
      chk("o_last", 192'(o_last), 192'(lst_q[0]));
    end
    acc = v && (grp_q.size() < 2);
    @(posedge i_clk);
    if (r && grp_q.size() > 0) begin
      void'(grp_q.pop_front());
      void'(lst_q.pop_front());
    end
    if (acc) begin
      part.push_back(p);
      if (part.size() == 8 || (PAD && l)) begin
        g = '0;
        for (int j = 0; j < 8; j++)
          g[24*j +: 24] = (j < part.size()) ? part[j] : p;
        grp_q.push_back(g);
        lst_q.push_back(PAD && l);
        part.delete();
      end
    end
    #1;
  endtask

  initial begin
    bit acc;
    int p;
    #2;
    chk("rst_valid", 192'(o_valid), 192'(0));
    chk("rst_last", 192'(o_last), 192'(0));
    chk("rst_data", dut_data, 192'(0));
    chk("rst_ready", 192'(o_ready), 192'(1));
    #10;
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // Basic pack 1..8
    for (int i = 1; i <= 8; i++) step(1'b1, 24'(i), 1'b0, 1'b1, acc);
    for (int i = 0; i < 3; i++) step(1'b0, 24'h0, 1'b0, 1'b1, acc);

    // Streaming 32 pixels
    for (int i = 0; i < 32; i++)
      step(1'b1, 24'h100000 + 24'(i), 1'b0, 1'b1, acc);
    for (int i = 0; i < 2; i++) step(1'b0, 24'h0, 1'b0, 1'b1, acc);

    // Backpressure: 1..17 offered, one drain cycle releases stall
    p = 1;
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 24'(p), 1'b0, (c == 18), acc);
      if (acc) p++;
    end
    chk("bp_accepted", 192'(p), 192'(18));
    while (p <= 24) begin
      step(1'b1, 24'(p), 1'b0, 1'b1, acc);
      if (acc) p++;
    end
    for (int i = 0; i < 3; i++) step(1'b0, 24'h0, 1'b0, 1'b1, acc);

    // Line-end: 0A,0B,0C with last on 0C, then 5 more pixels
    step(1'b1, 24'h0A, 1'b0, 1'b1, acc);
    step(1'b1, 24'h0B, 1'b0, 1'b1, acc);
    step(1'b1, 24'h0C, 1'b1, 1'b1, acc);
    step(1'b0, 24'h0, 1'b0, 1'b1, acc);
    for (int i = 0; i < 5; i++)
      step(1'b1, 24'h0D + 24'(i), 1'b0, 1'b1, acc);
    for (int i = 0; i < 2; i++) step(1'b0, 24'h0, 1'b0, 1'b1, acc);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) != 0), 24'($urandom),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0), acc);

    // Reset mid-group after 5 accepted pixels
    for (int i = 0; i < 8; i++) step(1'b0, 24'h0, 1'b0, 1'b1, acc);
    model_clear();
    for (int i = 0; i < 5; i++) step(1'b1, 24'h200 + 24'(i), 1'b0, 1'b1, acc);
    #3;
    i_rst = 1'b1;
    #1;
    chk("mid_rst_valid", 192'(o_valid), 192'(0));
    chk("mid_rst_data", dut_data, 192'(0));
    chk("mid_rst_ready", 192'(o_ready), 192'(1));
    model_clear();
    #1;
    i_rst = 1'b0;
    for (int i = 1; i <= 8; i++)
      step(1'b1, 24'hABC000 + 24'(i), 1'b0, 1'b1, acc);
    chk("post_rst_data", dut_data,
        {24'hABC008, 24'hABC007, 24'hABC006, 24'hABC005,
         24'hABC004, 24'hABC003, 24'hABC002, 24'hABC001});
    step(1'b0, 24'h0, 1'b0, 1'b1, acc);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/rgb_pixel_packer.md
# rgb_pixel_packer

Serial-to-parallel front end for the colour-space conversion stage. It accepts one 24-bit RGB pixel per clock over a valid/ready handshake and assembles groups of eight consecutive pixels. Each completed group is presented on eight parallel 24-bit lanes with a single `o_valid`, the shape consumed by the eight-lane RGB-to-YCbCr converter directly downstream. A two-level buffer (fill buffer plus output holding register) sustains one pixel per clock while the output drains.

## Interface
- No parameters. Lane count is fixed at 8 and pixel width is fixed at 24 bits (R[23:16], G[15:8], B[7:0]).
- `i_clk`  in  1  sole clock; all state updates on its rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_pixel`  in  24  input pixel.
- `i_valid`  in  1  `i_pixel` is valid.
- `i_last`  in  1  this pixel ends the line; qualified by `i_valid`.
- `o_ready`  out  1  block accepts `i_pixel` this cycle.
- `o_data1`..`o_data8`  out  24 each  packed group; `o_data1` holds the oldest pixel.
- `o_valid`  out  1  group on `o_data*` is valid.
- `o_last`  out  1  the group contains the line's final pixel.
- `i_ready`  in  1  downstream accepts the group. Tie to 1 when the converter is fed directly.

## Operation
- An input transfer occurs when `i_valid && o_ready`. An output transfer occurs when `o_valid && i_ready`.
- Fill buffer: 8 slots × 24 bits plus a fill count `cnt` (0..8). The accepted pixel is written to slot `cnt`, then `cnt` increments.
- Group completion: a transfer into slot 7 completes the group.
  - Moving to output: if the output register is empty or drains in the same cycle, the group moves into the output register on that edge and `cnt` becomes 0.
  - Stalling: otherwise `cnt` becomes 8 and the group stalls in the fill buffer.
  - Releasing a stall: while `cnt==8`, the group moves to the output register on the first edge where the output register is empty or draining, and `cnt` becomes 0 on that edge.
- `o_ready` = (`cnt` != 8). This is a combinational decode of registered state only and does not depend on `i_ready`.
- Output register: `o_valid`, `o_data*` and `o_last` are held unchanged while `o_valid && !i_ready`. After an output transfer with no new group arriving, `o_valid` clears on that edge.
- Simultaneous events:
  - Drain plus complete: an output transfer and a group completion on the same edge load the new group. `o_valid` stays 1 and there is no bubble.
  - Drain plus stall release: drain and release on the same edge behave the same way.
- Line-end padding is covered under Configuration.
- Reset mid-operation:
  - Any partial or stalled group is discarded, and the buffered output group is discarded.
  - After reset, `cnt`=0 and the output register is empty. The next accepted pixel starts a new group at `o_data1`.
- Reset values: `o_valid`=0, `o_last`=0, `o_data1`..`o_data8`=24'h0, `o_ready`=1 (because `cnt`=0).

## Timing
- Latency: the group appears on the outputs in the cycle after the edge that accepts its 8th pixel, provided the output register is free.
- Throughput: one pixel per clock and one group per 8 clocks when `i_ready`=1. `o_ready` never deasserts in that case.
- Under backpressure, at most 16 pixels are buffered: 8 in the output register and 8 stalled in the fill buffer.
- `o_ready` may only fall on the edge that sets `cnt`=8. It rises on the edge that releases the stall.
- All outputs except `o_ready` come directly from registers.

## Configuration
- Macro: `RGB_PACKER_LAST_PAD_EN`.
- Defined:
  - An accepted pixel with `i_last`=1 in slot k (k < 7) completes the group immediately.
  - Slots k+1..7 are filled with that same pixel value.
  - The group then follows the normal completion and stall rules, with `o_last`=1.
  - An `i_last` pixel in slot 7 completes the group normally with `o_last`=1.
- Not defined:
  - `i_last` is ignored and `o_last` is constant 0.
  - Groups complete only after 8 pixels; a partial group waits for later pixels.

## Test plan
- Basic pack: pixels 24'h000001..24'h000008 on consecutive cycles, `i_ready`=1 -> next cycle `o_valid`=1 for exactly one cycle, `o_data1`=24'h000001 .. `o_data8`=24'h000008, `o_ready` constantly 1.
- Streaming: 32 consecutive pixels, `i_ready`=1 -> four groups, `o_valid` pulses every 8 cycles, no `o_ready` deassertion, lane order preserved.
- Backpressure:
  - Stimulus: `i_ready`=0 and pixels 1..17 offered back-to-back.
  - Group 1 (pixels 1..8) is held stable on the outputs.
  - `o_ready` falls after pixel 16 is accepted, and pixel 17 is not accepted.
  - Raising `i_ready` for one cycle drains group 1; group 2 (9..16) appears next cycle, `o_ready` returns to 1, and pixel 17 is accepted.
- Line-end pad (macro defined): pixels 24'h0A, 24'h0B, 24'h0C with `i_last` on 24'h0C -> `o_data1..3`=0A,0B,0C, `o_data4..8`=24'h0C, `o_last`=1. Without the macro, no `o_valid` occurs until 5 more pixels arrive.
- Reset mid-group: accept 5 pixels, pulse `i_rst` asynchronously between edges -> outputs are 0 immediately and `o_ready`=1. The next 8 pixels P1..P8 appear as `o_data1`=P1..`o_data8`=P8.
